adau_audio_tx: RTL and testbench
================================

Name: adau_audio_tx

Overview:
- Consumer end of the stereo audio stream that cpu_bus_logic produces.
- Accepts 48-bit stereo sample writes from cpu_bus_logic (adau_audio/adau_audio_valid) and buffers them in a FIFO.
- Returns back-pressure to cpu_bus_logic via adau_audio_full.
- Drains the FIFO at frame rate as an I2S serial stream (bclk/lrclk/sdata) towards the ADAU codec; serialization is enabled only once codec init is done.

Parameters:
- DEPTH, 16, FIFO depth in stereo samples; power of two, minimum 2.
- BCLK_DIV, 8, clk cycles per bclk half-period; minimum 1, bclk period = 2*BCLK_DIV clk cycles.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- adau_audio  in  48  stereo sample; [47:24] left, [23:0] right, two's complement
- adau_audio_valid  in  1  single-cycle write strobe
- adau_audio_full  out  1  FIFO full; writes are dropped while high
- adau_init_done  in  1  codec configured; enables serializer
- bclk  out  1  I2S bit clock
- lrclk  out  1  I2S word select; 0 = left, 1 = right
- sdata  out  1  I2S serial data
- overflow  out  1  sticky: a write arrived while full
- underrun  out  1  sticky: a frame started with the FIFO empty

Behaviour:
- Reset (synchronous, active-high, any time, including mid-frame):
  - FIFO emptied; adau_audio_full=0.
  - bclk=0, lrclk=0, sdata=0; divider and bit counters = 0; overflow=0, underrun=0.
  - Block is idle in the cycle after reset deasserts.
- Write side:
  - Push when adau_audio_valid=1 and adau_audio_full=0.
  - adau_audio_full = (count==DEPTH), decoded from the registered count, so it updates the cycle after a push or pop.
  - valid=1 while full: sample dropped, overflow set.
- Serializer, gated by adau_init_done:
  - While adau_init_done=0: divider and bit counters held at 0; bclk, lrclk, sdata held at 0; FIFO contents untouched.
  - Dropping adau_init_done mid-frame aborts the frame immediately. The sample already loaded is discarded and is not re-read.
- Divider and bit counter:
  - div_cnt counts 0..BCLK_DIV-1; at wrap, bclk toggles.
  - bit_cnt (6 bits, 0..63) increments on each bclk falling edge and wraps 63->0.
  - lrclk = bit_cnt[5], updated with bit_cnt.
- Frame load:
  - Frame start is the cycle bit_cnt becomes 0, including the first falling edge after adau_init_done rises. The first bclk rising edge occurs BCLK_DIV cycles after enable.
  - At frame start, if the FIFO is non-empty: pop one sample into the left/right shift registers.
  - If empty: load zeros and set underrun.
- Data (I2S, one-bclk delay):
  - sdata changes only on bclk falling edges.
  - Slot 1..24: left[23] down to left[0].
  - Slot 33..56: right[23] down to right[0].
  - All other slots: 0.
  - The codec samples sdata on bclk rising edges.
- Simultaneous events:
  - Push and pop in the same cycle while full: the pop happens, and the push is rejected because full is registered (overflow set).
  - Push and pop in the same cycle while empty: the pop sees empty (underrun, zeros sent) and the push is accepted; count ends at 1.
  - Otherwise simultaneous push and pop leave count unchanged.
- Sticky flags: overflow and underrun clear only on reset.
- Ordering: samples leave in write order; no sample is duplicated or reordered.

Decomposition:
- Shared audio package holds:
  - constants AUDIO_SAMPLE_W=24, AUDIO_SLOT_W=32, AUDIO_FRAME_BITS=64;
  - left/right field offsets within the 48-bit word, shared with cpu_bus_logic.
- One sub-module: audio_fifo, a synchronous single-clock FIFO.
  - Parameters: width, depth.
  - Ports: push, pop, din, dout, full, empty, count.
  - Read data valid in the same cycle as pop (first-word fall-through).
- The serializer and divider stay in adau_audio_tx.

Test Plan:
1. Reset then idle, adau_init_done=0, BCLK_DIV=4 -> bclk, lrclk, sdata stay 0 for 1000 cycles; adau_audio_full=0; flags 0.
2. Write 0x123456_ABCDEF, then raise adau_init_done -> first frame is 512 clk cycles:
   - sdata sampled on bclk rising edges gives 0x123456 in slots 1..24 with lrclk=0;
   - gives 0xABCDEF in slots 33..56 with lrclk=1;
   - zeros elsewhere; underrun stays 0.
3. Write 16 samples (DEPTH=16) with init_done=0 -> adau_audio_full=1 the cycle after the 16th write. A 17th write sets overflow. After init, the 16 samples come out in order and the 17th never appears.
4. Init done with an empty FIFO -> frame of all-zero sdata and underrun=1. Then write 0x7FFFFF_800000 -> it appears in the next frame, not the current one.
5. Full FIFO; at the frame-start pop cycle, assert valid -> that sample is dropped and overflow set. Full deasserts one cycle later; count ends at 15.
6. Assert reset mid-frame (bit_cnt=40) with 5 samples queued -> next cycle all outputs are 0 and the FIFO is empty. After init, the output is zeros with underrun, and no stale data appears.

Source files
------------

// File: rtl/adau_audio_tx_pkg.sv
// Shared stereo audio constants and slot decoding used by the ADAU I2S transmitter
// and by the CPU-side producer that packs the 48-bit sample word.
package adau_audio_tx_pkg;

    localparam int AUDIO_SAMPLE_W   = 24;
    localparam int AUDIO_SLOT_W     = 32;
    localparam int AUDIO_FRAME_BITS = 64;
    localparam int AUDIO_WORD_W     = 2 * AUDIO_SAMPLE_W;
    localparam int AUDIO_LEFT_LSB   = 24;
    localparam int AUDIO_RIGHT_LSB  = 0;

    typedef logic [AUDIO_SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        SLOT_PAD   = 2'd0,
        SLOT_LEFT  = 2'd1,
        SLOT_RIGHT = 2'd2
    } slot_kind_e;

    // I2S carries each channel one bclk after the lrclk edge, MSB first.
    function automatic slot_kind_e slot_kind(input logic [5:0] slot);
        slot_kind_e kind;
        if ((slot >= 6'd1) && (slot <= 6'(AUDIO_SAMPLE_W))) begin
            kind = SLOT_LEFT;
        end else if ((slot >= 6'(AUDIO_SLOT_W + 1)) &&
                     (slot <= 6'(AUDIO_SLOT_W + AUDIO_SAMPLE_W))) begin
            kind = SLOT_RIGHT;
        end else begin
            kind = SLOT_PAD;
        end
        return kind;
    endfunction

endpackage

// File: rtl/adau_audio_tx_fifo.sv
// Single-clock first-word-fall-through FIFO; full/empty are registered decodes
// of the occupancy count, so they change the cycle after a push or pop.
module audio_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_L = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic [PTR_W:0]   count_next_s;
    logic             full_r;
    logic             empty_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests against the registered flags and compute the next occupancy.
    always_comb begin
        do_push_s = push && !full_r;
        do_pop_s  = pop && !empty_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_next_s = count_r + (PTR_W + 1)'(1);
            2'b01:   count_next_s = count_r - (PTR_W + 1)'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointer, count and flag registers; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == DEPTH_L);
            empty_r <= (count_next_s == '0);
        end
    end

    // Storage array, written only on accepted pushes.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;
    assign count = count_r;

endmodule

// File: rtl/adau_audio_tx.sv
// Buffers 48-bit stereo samples and drains one per 64-bit frame as an I2S stream
// (bclk/lrclk/sdata) once the codec reports its configuration is complete.
module adau_audio_tx
    import adau_audio_tx_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int BCLK_DIV = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [AUDIO_WORD_W-1:0] adau_audio,
    input  logic                    adau_audio_valid,
    output logic                    adau_audio_full,
    input  logic                    adau_init_done,
    output logic                    bclk,
    output logic                    lrclk,
    output logic                    sdata,
    output logic                    overflow,
    output logic                    underrun
);
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0]        div_cnt_r;
    logic [5:0]              bit_cnt_r;
    logic                    bclk_r;
    logic                    lrclk_r;
    logic                    sdata_r;
    logic                    started_r;
    logic                    overflow_r;
    logic                    underrun_r;
    sample_t                 left_sr_r;
    sample_t                 right_sr_r;

    logic                    div_wrap_s;
    logic                    fall_s;
    logic                    frame_start_s;
    logic                    push_s;
    logic                    pop_s;
    logic [5:0]              bit_next_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [AUDIO_WORD_W-1:0] fifo_dout_s;
    logic [$clog2(DEPTH):0]  fifo_count_s;
    logic                    count_unused_s;

    audio_fifo #(
        .WIDTH (AUDIO_WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (adau_audio),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign count_unused_s = ^fifo_count_s;

    // Edge detection; the first falling edge after enable opens a frame without advancing bit_cnt.
    always_comb begin
        div_wrap_s = adau_init_done && (div_cnt_r == DIV_LAST);
        fall_s     = div_wrap_s && bclk_r;
        if (started_r) begin
            bit_next_s = bit_cnt_r + 6'd1;
        end else begin
            bit_next_s = 6'd0;
        end
        frame_start_s = fall_s && (bit_next_s == 6'd0);
        pop_s         = frame_start_s && !fifo_empty_s;
        push_s        = adau_audio_valid && !fifo_full_s;
    end

    // Bit-clock divider and serializer; all state collapses to zero while the codec is not ready.
    always_ff @(posedge clk) begin
        if (reset || !adau_init_done) begin
            div_cnt_r  <= '0;
            bit_cnt_r  <= 6'd0;
            bclk_r     <= 1'b0;
            lrclk_r    <= 1'b0;
            sdata_r    <= 1'b0;
            started_r  <= 1'b0;
            left_sr_r  <= '0;
            right_sr_r <= '0;
        end else begin
            div_cnt_r <= div_wrap_s ? '0 : div_cnt_r + DIV_W'(1);
            if (div_wrap_s) begin
                bclk_r <= ~bclk_r;
            end
            if (fall_s) begin
                bit_cnt_r <= bit_next_s;
                lrclk_r   <= bit_next_s[5];
                started_r <= 1'b1;
                if (frame_start_s) begin
                    sdata_r <= 1'b0;
                    if (!fifo_empty_s) begin
                        left_sr_r  <= fifo_dout_s[AUDIO_LEFT_LSB +: AUDIO_SAMPLE_W];
                        right_sr_r <= fifo_dout_s[AUDIO_RIGHT_LSB +: AUDIO_SAMPLE_W];
                    end else begin
                        left_sr_r  <= '0;
                        right_sr_r <= '0;
                    end
                end else begin
                    case (slot_kind(bit_next_s))
                        SLOT_LEFT: begin
                            sdata_r   <= left_sr_r[AUDIO_SAMPLE_W-1];
                            left_sr_r <= {left_sr_r[AUDIO_SAMPLE_W-2:0], 1'b0};
                        end
                        SLOT_RIGHT: begin
                            sdata_r    <= right_sr_r[AUDIO_SAMPLE_W-1];
                            right_sr_r <= {right_sr_r[AUDIO_SAMPLE_W-2:0], 1'b0};
                        end
                        default: begin
                            sdata_r <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            if (adau_audio_valid && fifo_full_s) begin
                overflow_r <= 1'b1;
            end
            if (frame_start_s && fifo_empty_s) begin
                underrun_r <= 1'b1;
            end
        end
    end

    assign adau_audio_full = fifo_full_s;
    assign bclk            = bclk_r;
    assign lrclk           = lrclk_r;
    assign sdata           = sdata_r;
    assign overflow        = overflow_r;
    assign underrun        = underrun_r;

endmodule

// File: tb/tb_adau_audio_tx.sv
// Directed bench for adau_audio_tx: records (sdata, lrclk) at every bclk rising edge
// and compares whole 64-slot frames against hand-built I2S images.
module tb_adau_audio_tx;
    localparam int DEPTH    = 16;
    localparam int BCLK_DIV = 4;

    typedef struct {
        logic [47:0] din;
        logic [23:0] left;
        logic [23:0] right;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [47:0] adau_audio;
    logic        adau_audio_valid;
    logic        adau_audio_full;
    logic        adau_init_done;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        overflow;
    logic        underrun;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t_pre = 0;
    logic prev_bclk = 1'b0;
    logic sd_q[$];
    logic lr_q[$];
    int   rc_q[$];
    vec_t vecs[4];

    adau_audio_tx #(
        .DEPTH    (DEPTH),
        .BCLK_DIV (BCLK_DIV)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .adau_audio       (adau_audio),
        .adau_audio_valid (adau_audio_valid),
        .adau_audio_full  (adau_audio_full),
        .adau_init_done   (adau_init_done),
        .bclk             (bclk),
        .lrclk            (lrclk),
        .sdata            (sdata),
        .overflow         (overflow),
        .underrun         (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock; capture the codec's view at each bclk rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bclk && !prev_bclk) begin
            sd_q.push_back(sdata);
            lr_q.push_back(lrclk);
            rc_q.push_back(cyc);
        end
        prev_bclk = bclk;
    endtask

    task automatic clear_capture();
        sd_q.delete();
        lr_q.delete();
        rc_q.delete();
    endtask

    task automatic fill_to(input int n);
        int guard = 0;
        while ((sd_q.size() < n) && (guard < 20000)) begin
            step();
            guard++;
        end
        if (sd_q.size() < n) chk("rise_timeout", 64'(sd_q.size()), 64'(n));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        adau_audio_valid = 1'b0;
        adau_init_done = 1'b0;
        step();
        step();
        reset = 1'b0;
        clear_capture();
    endtask

    task automatic write(input logic [47:0] d);
        adau_audio = d;
        adau_audio_valid = 1'b1;
        step();
        adau_audio_valid = 1'b0;
    endtask

    // Enable the serializer and discard the lone rising edge that precedes the first frame.
    task automatic start_frames();
        adau_init_done = 1'b1;
        clear_capture();
        fill_to(1);
        t_pre = rc_q[0];
        clear_capture();
    endtask

    function automatic logic [47:0] samp(input int i);
        return {24'h010101 * 24'(i + 1), 24'hFEDCBA - 24'(i)};
    endfunction

    function automatic logic [63:0] exp_frame(input logic [23:0] l, input logic [23:0] r);
        logic [63:0] e;
        e = 64'd0;
        for (int k = 1; k <= 24; k++) e[k] = l[24-k];
        for (int k = 33; k <= 56; k++) e[k] = r[56-k];
        return e;
    endfunction

    function automatic logic [63:0] frame_sd(input int base);
        logic [63:0] f;
        for (int k = 0; k < 64; k++) f[k] = sd_q[base+k];
        return f;
    endfunction

    function automatic logic [63:0] frame_lr(input int base);
        logic [63:0] f;
        for (int k = 0; k < 64; k++) f[k] = lr_q[base+k];
        return f;
    endfunction

    initial begin
        logic [2:0]  act;
        logic [47:0] s;

        reset = 1'b1;
        adau_audio = 48'd0;
        adau_audio_valid = 1'b0;
        adau_init_done = 1'b0;

        vecs[0] = '{48'h123456_ABCDEF, 24'h123456, 24'hABCDEF};
        vecs[1] = '{48'h7FFFFF_800000, 24'h7FFFFF, 24'h800000};
        vecs[2] = '{48'hFFFFFF_000001, 24'hFFFFFF, 24'h000001};
        vecs[3] = '{48'hA5A5A5_5A5A5A, 24'hA5A5A5, 24'h5A5A5A};

        // Idle with the codec not ready.
        do_reset();
        chk("reset_outputs", {61'd0, bclk, lrclk, sdata}, 64'd0);
        act = 3'b000;
        repeat (1000) begin
            step();
            act = act | {bclk, lrclk, sdata};
        end
        chk("idle_activity", 64'(act), 64'd0);
        chk("idle_full", 64'(adau_audio_full), 64'd0);
        chk("idle_flags", {62'd0, overflow, underrun}, 64'd0);

        // Single-sample frames from the vector table.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            write(vecs[v].din);
            start_frames();
            fill_to(64);
            chk($sformatf("v%0d_sdata", v), frame_sd(0), exp_frame(vecs[v].left, vecs[v].right));
            chk($sformatf("v%0d_lrclk", v), frame_lr(0), 64'hFFFFFFFF_00000000);
            chk($sformatf("v%0d_frame_len", v), 64'(rc_q[63] - t_pre), 64'd512);
            chk($sformatf("v%0d_underrun", v), 64'(underrun), 64'd0);
        end

        // Fill to DEPTH, overflow on the 17th, then drain in order.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            write(samp(i));
            if (i == DEPTH - 2) chk("full_at_15", 64'(adau_audio_full), 64'd0);
            if (i == DEPTH - 1) chk("full_at_16", 64'(adau_audio_full), 64'd1);
        end
        chk("overflow_before_17th", 64'(overflow), 64'd0);
        write(48'hDEAD00_00BEEF);
        chk("overflow_17th", 64'(overflow), 64'd1);
        start_frames();
        fill_to(DEPTH * 64);
        for (int i = 0; i < DEPTH; i++) begin
            s = samp(i);
            chk($sformatf("drain_%0d", i), frame_sd(i * 64), exp_frame(s[47:24], s[23:0]));
        end
        chk("drain_no_underrun", 64'(underrun), 64'd0);
        fill_to((DEPTH + 1) * 64);
        chk("drain_17th_absent", frame_sd(DEPTH * 64), 64'd0);
        chk("drain_underrun", 64'(underrun), 64'd1);

        // Empty FIFO at enable, then a write lands in the following frame.
        do_reset();
        start_frames();
        chk("empty_pre_frame_underrun", 64'(underrun), 64'd0);
        fill_to(10);
        chk("empty_underrun", 64'(underrun), 64'd1);
        write(48'h7FFFFF_800000);
        fill_to(128);
        chk("empty_frame0_zero", frame_sd(0), 64'd0);
        chk("empty_frame1_data", frame_sd(64), exp_frame(24'h7FFFFF, 24'h800000));

        // Push while full in the same cycle as the first frame-start pop.
        do_reset();
        for (int i = 0; i < DEPTH; i++) write(samp(i));
        adau_init_done = 1'b1;
        clear_capture();
        repeat (2 * BCLK_DIV - 1) step();
        chk("popcycle_full_before", 64'(adau_audio_full), 64'd1);
        adau_audio = 48'hBAD000_000BAD;
        adau_audio_valid = 1'b1;
        step();
        adau_audio_valid = 1'b0;
        chk("popcycle_overflow", 64'(overflow), 64'd1);
        chk("popcycle_full_after", 64'(adau_audio_full), 64'd0);
        write(48'h0F0F0F_F0F0F0);
        chk("popcycle_count15", 64'(adau_audio_full), 64'd1);
        fill_to(129);
        s = samp(0);
        chk("popcycle_frame0", frame_sd(1), exp_frame(s[47:24], s[23:0]));
        s = samp(1);
        chk("popcycle_frame1", frame_sd(65), exp_frame(s[47:24], s[23:0]));

        // Reset mid-frame (bit_cnt=40) with five samples still queued.
        do_reset();
        for (int i = 0; i < 6; i++) write(samp(i + 4));
        start_frames();
        fill_to(41);
        chk("midframe_lrclk", 64'(lrclk), 64'd1);
        reset = 1'b1;
        adau_init_done = 1'b0;
        step();
        chk("midreset_outputs", {61'd0, bclk, lrclk, sdata}, 64'd0);
        chk("midreset_full", 64'(adau_audio_full), 64'd0);
        chk("midreset_flags", {62'd0, overflow, underrun}, 64'd0);
        reset = 1'b0;
        step();
        start_frames();
        fill_to(128);
        chk("postreset_frame0", frame_sd(0), 64'd0);
        chk("postreset_frame1", frame_sd(64), 64'd0);
        chk("postreset_underrun", 64'(underrun), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
